word_register: RTL and testbench

- Single-clock, parameterised holding register with an active-low write strobe and per-byte write lanes.
- Captures `in` on a rising `clk` edge when `write_n`=0; holds otherwise; drives the stored word continuously on `out`.
- General-purpose state element for datapaths and CSR-style storage (e.g. pipeline latches, register-file building block).

---
 rtl/word_register.sv | 93 +++++++++
 tb/tb_word_register.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/word_register.sv
`default_nettype none
// ============================================================================
//  Module      : word_register
//  Description : Parameterised holding register with an active-low write
//                strobe, per-byte write lanes and a one-cycle "written"
//                pulse. Asynchronous active-high reset.
//                Optional feature (macro WORD_REGISTER_PARITY_EN): stored
//                even-parity bit plus a sticky parity-error flag.
//  Revision    : 1.0 - initial release
// ============================================================================
module word_register #(
    parameter int               WIDTH       = 32,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 write_n,
    input  logic [WIDTH-1:0]     in,
    input  logic [WIDTH/8-1:0]   byte_en,
`ifdef WORD_REGISTER_PARITY_EN
    input  logic                 parity_chk_n,
    output logic                 parity,
    output logic                 parity_err,
`endif
    output logic [WIDTH-1:0]     out,
    output logic                 written
);

    localparam int c_lanes = WIDTH / 8;

    logic [WIDTH-1:0] value_q;
    logic [WIDTH-1:0] value_d;
    logic             written_q;
    logic             written_d;

    // Next value: enabled lanes take the new byte during a write, the rest hold.
    always_comb begin
        value_d = value_q;
        for (int k = 0; k < c_lanes; k++) begin
            if (!write_n && byte_en[k]) begin
                value_d[8*k +: 8] = in[8*k +: 8];
            end
        end
    end

    // The pulse follows the strobe alone, so an all-lanes-off write still reports.
    always_comb begin
        written_d = ~write_n;
    end

    // State register; reset takes effect immediately without a clock.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            value_q   <= RESET_VALUE;
            written_q <= 1'b0;
        end else begin
            value_q   <= value_d;
            written_q <= written_d;
        end
    end

    assign out     = value_q;
    assign written = written_q;

`ifdef WORD_REGISTER_PARITY_EN
    logic parity_q;
    logic parity_d;
    logic parity_err_q;
    logic parity_err_d;

    // Parity is computed from the next value so it always travels with it.
    always_comb begin
        parity_d     = ^value_d;
        parity_err_d = parity_err_q | (~parity_chk_n & ((^value_q) != parity_q));
    end

    // Stored parity and sticky error flag, cleared only by reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            parity_q     <= ^RESET_VALUE;
            parity_err_q <= 1'b0;
        end else begin
            parity_q     <= parity_d;
            parity_err_q <= parity_err_d;
        end
    end

    assign parity     = parity_q;
    assign parity_err = parity_err_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_word_register.sv
`default_nettype none
// ============================================================================
//  Module      : tb_word_register
//  Description : Self-checking bench for word_register (WIDTH=32).
//                Table-driven vectors, hand-written reset/timing sequences
//                and randomized traffic against a byte-array model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_word_register;

    logic        clk;
    logic        rst;
    logic        write_n;
    logic [31:0] in;
    logic [3:0]  byte_en;
    logic [31:0] out;
    logic        written;
`ifdef WORD_REGISTER_PARITY_EN
    logic        parity_chk_n;
    logic        parity;
    logic        parity_err;
`endif

    int checks = 0;
    int errors = 0;

    // Reference model: four independent byte cells plus the pulse flag.
    bit [7:0] mdl_byte [4];
    bit       mdl_written;

    word_register #(.WIDTH(32), .RESET_VALUE(32'h0)) dut (
        .clk          (clk),
        .rst          (rst),
        .write_n      (write_n),
        .in           (in),
        .byte_en      (byte_en),
`ifdef WORD_REGISTER_PARITY_EN
        .parity_chk_n (parity_chk_n),
        .parity       (parity),
        .parity_err   (parity_err),
`endif
        .out          (out),
        .written      (written)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic        wn;
        logic [3:0]  be;
        logic [31:0] din;
        logic [31:0] exp_out;
        logic        exp_wr;
    } vec_t;

    vec_t vecs [9];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] mdl_value();
        return {mdl_byte[3], mdl_byte[2], mdl_byte[1], mdl_byte[0]};
    endfunction

    task automatic mdl_reset();
        for (int k = 0; k < 4; k++) mdl_byte[k] = 8'h00;
        mdl_written = 1'b0;
    endtask

    task automatic mdl_clock(input logic wn, input logic [3:0] be, input logic [31:0] d);
        if (!wn) begin
            for (int k = 0; k < 4; k++)
                if (be[k]) mdl_byte[k] = d[8*k +: 8];
        end
        mdl_written = !wn;
    endtask

    // Drive inputs, take one rising edge, then settle past it.
    task automatic step(input logic wn, input logic [3:0] be, input logic [31:0] d);
        write_n = wn;
        byte_en = be;
        in      = d;
        @(posedge clk);
        #1;
        mdl_clock(wn, be, d);
    endtask

    task automatic chk_model(input string name);
        chk({name, "_out"}, out, mdl_value());
        chk({name, "_written"}, {31'b0, written}, {31'b0, mdl_written});
    endtask

    initial begin
        rst     = 1'b1;
        write_n = 1'b1;
        byte_en = 4'h0;
        in      = 32'h0;
`ifdef WORD_REGISTER_PARITY_EN
        parity_chk_n = 1'b0;
`endif
        mdl_reset();

        // Power-up: reset applied from time zero, no edge needed.
        #2;
        chk("reset_out", out, 32'h0);
        chk("reset_written", {31'b0, written}, 32'h0);
        #8;
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step(1'b1, 4'hF, 32'hFFFF_FFFF);
            chk_model("idle_after_reset");
        end

        // Table-driven write/hold/byte-lane vectors.
        vecs[0] = '{1'b0, 4'hF, 32'd123,        32'd123,        1'b1};
        vecs[1] = '{1'b1, 4'hF, 32'd0,          32'd123,        1'b0};
        vecs[2] = '{1'b1, 4'h0, 32'hFFFF_FFFF,  32'd123,        1'b0};
        vecs[3] = '{1'b0, 4'hF, 32'h1122_3344,  32'h1122_3344,  1'b1};
        vecs[4] = '{1'b0, 4'h5, 32'hAABB_CCDD,  32'h11BB_33DD,  1'b1};
        vecs[5] = '{1'b0, 4'h0, 32'hDEAD_BEEF,  32'h11BB_33DD,  1'b1};
        vecs[6] = '{1'b1, 4'hF, 32'h0,          32'h11BB_33DD,  1'b0};
        vecs[7] = '{1'b0, 4'h8, 32'hFF00_0000,  32'hFFBB_33DD,  1'b1};
        vecs[8] = '{1'b0, 4'h2, 32'h0000_1200,  32'hFFBB_12DD,  1'b1};
        for (int i = 0; i < 9; i++) begin
            step(vecs[i].wn, vecs[i].be, vecs[i].din);
            chk($sformatf("vec%0d_out", i), out, vecs[i].exp_out);
            chk($sformatf("vec%0d_written", i), {31'b0, written}, {31'b0, vecs[i].exp_wr});
        end

        // Write 123 then hold for 10 edges with in=0.
        step(1'b0, 4'hF, 32'd123);
        chk_model("write123");
        for (int i = 0; i < 10; i++) begin
            step(1'b1, 4'hF, 32'd0);
            chk_model("hold123");
        end

        // Strobe glitch between edges must not write.
        #1;
        write_n = 1'b0;
        in      = 32'h5555_5555;
        #2;
        write_n = 1'b1;
        chk("glitch_between_edges", out, 32'd123);
        @(posedge clk);
        #1;
        mdl_clock(1'b1, 4'hF, 32'h0);
        chk_model("glitch_no_write");

        // Async reset mid-hold: out clears without a clock edge.
        #2;
        rst = 1'b1;
        #1;
        chk("async_reset_out", out, 32'h0);
        #4;
        rst = 1'b0;
        mdl_reset();
        for (int i = 0; i < 10; i++) begin
            step(1'b1, 4'hF, 32'hA5A5_A5A5);
            chk_model("hold_after_reset");
        end

        // Reset held across an edge with a write pending overrides it.
        step(1'b0, 4'hF, 32'h0BAD_F00D);
        chk_model("pre_override_write");
        write_n = 1'b0;
        in      = 32'h1234_5678;
        #1;
        rst = 1'b1;
        #1;
        chk("reset_clears_written", {31'b0, written}, 32'h0);
        @(posedge clk);
        #1;
        chk("reset_over_edge_out", out, 32'h0);
        rst = 1'b0;
        mdl_reset();

        // Write 546 after reset, then hold with in=0.
        step(1'b0, 4'hF, 32'd546);
        chk_model("write546");
        step(1'b1, 4'hF, 32'd0);
        chk_model("hold546");

`ifdef WORD_REGISTER_PARITY_EN
        step(1'b0, 4'hF, 32'h0000_0007);
        chk("parity_7", {31'b0, parity}, 32'h1);
        step(1'b0, 4'hF, 32'h0000_0003);
        chk("parity_3", {31'b0, parity}, 32'h0);
        #1;
        rst = 1'b1;
        #1;
        chk("parity_reset", {31'b0, parity}, 32'h0);
        rst = 1'b0;
        mdl_reset();
`endif

        // Randomized traffic with occasional asynchronous resets.
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 39) == 0) begin
                #2;
                rst = 1'b1;
                #1;
                mdl_reset();
                chk("rand_async_reset", out, mdl_value());
                #2;
                rst = 1'b0;
            end
            step(($urandom_range(0, 2) == 0), 4'($urandom), 32'($urandom));
            chk_model("random");
        end

`ifdef WORD_REGISTER_PARITY_EN
        chk("parity_err_clear", {31'b0, parity_err}, 32'h0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Absolute time bound so the run always ends.
    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
